// File: rtl/obi_rr_arbiter_n_to_one_if.sv
// obi_rr_arbiter_n_to_one_if: upstream-master and downstream-slave OBI signals around the arbiter
interface obi_rr_arbiter_n_to_one_if #(
  parameter int NMASTER = 4
);
  logic [NMASTER-1:0]    m_req_i;
  logic [NMASTER*32-1:0] m_addr_i;
  logic [NMASTER-1:0]    m_we_i;
  logic [NMASTER*4-1:0]  m_be_i;
  logic [NMASTER*32-1:0] m_wdata_i;
  logic [NMASTER-1:0]    m_gnt_o;
  logic [NMASTER-1:0]    m_rvalid_o;
  logic [31:0]           m_rdata_o;
  logic                  s_req_o;
  logic [31:0]           s_addr_o;
  logic                  s_we_o;
  logic [3:0]            s_be_o;
  logic [31:0]           s_wdata_o;
  logic                  s_gnt_i;
  logic                  s_rvalid_i;
  logic [31:0]           s_rdata_i;
  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
  );
  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
  );
endinterface

// File: rtl/obi_rr_arbiter_n_to_one.sv
// obi_rr_arbiter_n_to_one: round-robin N-to-1 OBI arbiter with in-order response routing
module obi_rr_arbiter_n_to_one #(
  parameter int NMASTER = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = $clog2(NMASTER),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
  localparam int PTR_W = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  obi_rr_arbiter_n_to_one_if.slave bus,
  output logic [CNT_W-1:0]        outstanding_o,
  output logic                    unexpected_rvalid_o
);
  logic [IDX_W-1:0] rr_ptr, winner, cand, head;
  logic [IDX_W-1:0] fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic full, hs, pop;
  // descending scan so the requester closest to rr_ptr is the last to overwrite winner
  always_comb begin
    winner = rr_ptr;
    cand = rr_ptr;
    for (int i = NMASTER - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NMASTER);
      winner = bus.m_req_i[cand] ? cand : winner;
    end
  end
  assign full = count == CNT_W'(MAX_OUTSTANDING);
  assign bus.s_req_o = (|bus.m_req_i) & ~full;
  assign hs = bus.s_req_o & bus.s_gnt_i;
  assign pop = bus.s_rvalid_i & (count != '0);
  assign unexpected_rvalid_o = bus.s_rvalid_i & (count == '0);
  assign head = fifo[rd_ptr];
  assign bus.s_addr_o = bus.s_req_o ? bus.m_addr_i[32*winner +: 32] : '0;
  assign bus.s_we_o = bus.s_req_o ? bus.m_we_i[winner] : 1'b0;
  assign bus.s_be_o = bus.s_req_o ? bus.m_be_i[4*winner +: 4] : '0;
  assign bus.s_wdata_o = bus.s_req_o ? bus.m_wdata_i[32*winner +: 32] : '0;
  assign bus.m_gnt_o = hs ? NMASTER'(1) << winner : '0;
  assign bus.m_rvalid_o = pop ? NMASTER'(1) << head : '0;
  assign bus.m_rdata_o = bus.s_rdata_i;
  assign outstanding_o = count;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (hs) begin
        rr_ptr <= winner == IDX_W'(NMASTER - 1) ? '0 : winner + 1'b1;
        wr_ptr <= wr_ptr == PTR_W'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PTR_W'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(hs) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk_i) if (hs) fifo[wr_ptr] <= winner;
endmodule
